// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Groups the fetch unit's control, memory and instruction signals.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    logic [15:0] newPC;
    logic        redirect;
    logic        halt;
    logic        stall;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_busy;
    logic        imem_done;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_inc;
    logic        halted;
    logic        err;

    modport master (
        output newPC, redirect, halt, stall, imem_busy, imem_done, imem_data,
        input  imem_rd, imem_addr, instr, instr_valid, pc_out, pc_inc, halted, err
    );

    modport slave (
        input  newPC, redirect, halt, stall, imem_busy, imem_done, imem_data,
        output imem_rd, imem_addr, instr, instr_valid, pc_out, pc_inc, halted, err
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch with stall, redirect, halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc_out_q;
    logic [15:0] pc_inc_q;
    logic        valid_q;
    logic        halted_q;
    logic        err_q;
    logic        drop_q;
    logic        issue;
    logic [15:0] pc_plus2;

    // A redirect in REQ retargets the PC instead of issuing from the stale one.
    assign issue         = (state_q == S_REQ) && !bus.imem_busy && !bus.redirect && !rst;
    assign pc_plus2      = pc_q + 16'd2;

    assign bus.imem_rd     = issue;
    assign bus.imem_addr   = {pc_q[15:1], 1'b0};
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.pc_inc      = pc_inc_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= 16'h0000;
            instr_q  <= 16'h0000;
            pc_out_q <= 16'h0000;
            pc_inc_q <= 16'h0002;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.redirect) begin
                        pc_q <= bus.newPC;
                    end else if (issue) begin
                        state_q <= S_WAIT;
                        if (pc_q[0]) err_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // The in-flight response must still be absorbed after a redirect.
                    if (bus.redirect) begin
                        pc_q <= bus.newPC;
                        if (bus.imem_done) begin
                            state_q <= S_REQ;
                            drop_q  <= 1'b0;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end else if (bus.imem_done) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            instr_q  <= bus.imem_data;
                            pc_out_q <= pc_q;
                            pc_inc_q <= pc_plus2;
                            pc_q     <= pc_plus2;
                            valid_q  <= 1'b1;
                            state_q  <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.redirect) begin
                        pc_q    <= bus.newPC;
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                    end else if (bus.halt) begin
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALTED;
                    end else if (!bus.stall) begin
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Vector table, directed corner cases and randomized model check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [15:0] data;
        logic        redir;
        logic [15:0] npc;
        logic        hlt;
        logic        stl;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pcout;
        logic [15:0] e_pcinc;
        logic        e_halted;
        logic        e_err;
    } vec_t;

    vec_t vt [15];

    // Reference model: a fetch is either outstanding, held for the consumer,
    // or neither; a redirect during an outstanding fetch poisons its response.
    logic [15:0] m_pc, m_instr, m_pcout, m_pcinc;
    logic        m_out, m_discard, m_valid, m_halted, m_err;
    int          lat;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_rd, input logic [15:0] e_addr,
                              input logic e_valid, input logic [15:0] e_instr,
                              input logic [15:0] e_pcout, input logic [15:0] e_pcinc,
                              input logic e_halted, input logic e_err);
        chk({tag, ".imem_rd"}, {15'd0, bus.imem_rd}, {15'd0, e_rd});
        if (e_rd) chk({tag, ".imem_addr"}, bus.imem_addr, e_addr);
        chk({tag, ".instr_valid"}, {15'd0, bus.instr_valid}, {15'd0, e_valid});
        if (e_valid) begin
            chk({tag, ".instr"}, bus.instr, e_instr);
            chk({tag, ".pc_out"}, bus.pc_out, e_pcout);
            chk({tag, ".pc_inc"}, bus.pc_inc, e_pcinc);
        end
        chk({tag, ".halted"}, {15'd0, bus.halted}, {15'd0, e_halted});
        chk({tag, ".err"}, {15'd0, bus.err}, {15'd0, e_err});
    endtask

    task automatic apply(input logic busy, input logic done, input logic [15:0] data,
                         input logic redir, input logic [15:0] npc,
                         input logic hlt, input logic stl);
        @(negedge clk);
        rst           = 1'b0;
        bus.imem_busy = busy;
        bus.imem_done = done;
        bus.imem_data = data;
        bus.redirect  = redir;
        bus.newPC     = npc;
        bus.halt      = hlt;
        bus.stall     = stl;
        #1;
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pcout = 16'h0000; m_pcinc = 16'h0002;
        m_out = 1'b0; m_discard = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
        lat = 0;
    endtask

    // Asserts reset mid-cycle and checks the outputs respond without a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.imem_busy = 1'b0; bus.imem_done = 1'b0; bus.imem_data = 16'h0000;
        bus.redirect = 1'b0; bus.newPC = 16'h0000; bus.halt = 1'b0; bus.stall = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk({tag, ".rst_rd"}, {15'd0, bus.imem_rd}, 16'd0);
        chk({tag, ".rst_addr"}, bus.imem_addr, 16'h0000);
        chk({tag, ".rst_valid"}, {15'd0, bus.instr_valid}, 16'd0);
        chk({tag, ".rst_instr"}, bus.instr, 16'h0000);
        chk({tag, ".rst_pc_out"}, bus.pc_out, 16'h0000);
        chk({tag, ".rst_pc_inc"}, bus.pc_inc, 16'h0002);
        chk({tag, ".rst_halted"}, {15'd0, bus.halted}, 16'd0);
        chk({tag, ".rst_err"}, {15'd0, bus.err}, 16'd0);
        model_reset();
    endtask

    task automatic model_step(input logic busy, input logic done, input logic [15:0] data,
                              input logic redir, input logic [15:0] npc,
                              input logic hlt, input logic stl, output logic issued);
        issued = 1'b0;
        if (m_halted) return;
        if (redir) begin
            if (m_out) begin
                if (done) begin
                    m_out = 1'b0;
                    m_discard = 1'b0;
                end else begin
                    m_discard = 1'b1;
                end
            end
            m_pc    = npc;
            m_valid = 1'b0;
        end else if (m_out) begin
            if (done) begin
                m_out = 1'b0;
                if (m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    m_instr = data;
                    m_pcout = m_pc;
                    m_pcinc = m_pc + 16'd2;
                    m_pc    = m_pc + 16'd2;
                    m_valid = 1'b1;
                end
            end
        end else if (m_valid) begin
            if (hlt) begin
                m_halted = 1'b1;
                m_valid  = 1'b0;
            end else if (!stl) begin
                m_valid = 1'b0;
            end
        end else if (!busy) begin
            m_out  = 1'b1;
            issued = 1'b1;
            if (m_pc[0]) m_err = 1'b1;
        end
    endtask

    initial begin
        logic        r_busy, r_done, r_redir, r_hlt, r_stl, e_rd, issued;
        logic [15:0] r_data, r_npc;

        rst = 1'b1;
        bus.imem_busy = 1'b0; bus.imem_done = 1'b0; bus.imem_data = 16'h0000;
        bus.redirect = 1'b0; bus.newPC = 16'h0000; bus.halt = 1'b0; bus.stall = 1'b0;
        model_reset();

        //           busy done data    rdr npc      h  s   rd addr     v  instr    pc_out   pc_inc   hd er
        vt[0]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0, 1'b1,16'h0000,1'b0,16'h0000,16'h0000,16'h0002,1'b0,1'b0};
        vt[1]  = '{1'b0,1'b1,16'h1234,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0002,1'b0,1'b0};
        vt[2]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[3]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[4]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[5]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[6]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[7]  = '{1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,1'b0,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[8]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0, 1'b1,16'h0002,1'b0,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[9]  = '{1'b0,1'b0,16'h0000,1'b1,16'h0040,1'b0,1'b0, 1'b0,16'h0000,1'b0,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[10] = '{1'b0,1'b1,16'hDEAD,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,1'b0,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[11] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0, 1'b1,16'h0040,1'b0,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[12] = '{1'b0,1'b1,16'h0F0F,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,1'b0,16'h1234,16'h0000,16'h0002,1'b0,1'b0};
        vt[13] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,1'b1,16'h0F0F,16'h0040,16'h0042,1'b0,1'b0};
        vt[14] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,1'b0,16'h0F0F,16'h0040,16'h0042,1'b1,1'b0};

        do_reset("init");
        for (int i = 0; i < 15; i++) begin
            apply(vt[i].busy, vt[i].done, vt[i].data, vt[i].redir, vt[i].npc, vt[i].hlt, vt[i].stl);
            check_outs($sformatf("vec%0d", i), vt[i].e_rd, vt[i].e_addr, vt[i].e_valid,
                       vt[i].e_instr, vt[i].e_pcout, vt[i].e_pcinc, vt[i].e_halted, vt[i].e_err);
        end
        chk("halt.instr_frozen", bus.instr, 16'h0F0F);
        chk("halt.pc_out_frozen", bus.pc_out, 16'h0040);

        // Halted: nothing but reset may wake the unit.
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'(i % 3 == 0), 16'h5555, 1'(i % 4 == 1), 16'h0080, 1'b0, 1'b0);
            check_outs($sformatf("halted%0d", i), 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        end
        do_reset("unhalt");

        // PC wrap at the top of the address space, then redirect colliding with done.
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        check_outs("wrap.redir", 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("wrap.rd", 1'b1, 16'hFFFE, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("wrap.hold", 1'b0, 16'h0000, 1'b1, 16'hAAAA, 16'hFFFE, 16'h0000, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("wrap.next", 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 16'hBBBB, 1'b1, 16'h0200, 1'b0, 1'b0);
        check_outs("coll.cycle", 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("coll.rd", 1'b1, 16'h0200, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("coll.instr_kept", bus.instr, 16'hAAAA);

        // Misaligned redirect from HOLD: sticky err, aligned address issued.
        apply(1'b0, 1'b1, 16'hCCCC, 1'b0, 16'h0000, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b0, 1'b1);
        check_outs("mis.hold", 1'b0, 16'h0000, 1'b1, 16'hCCCC, 16'h0200, 16'h0202, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("mis.rd", 1'b1, 16'h0100, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 16'h7777, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("mis.err", 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) apply(1'b0, 1'(i == 2), 16'h0000, 1'(i == 0), 16'h0010, 1'b0, 1'b0);
        chk("mis.err_sticky", {15'd0, bus.err}, 16'd1);
        do_reset("mis");

        // Reset abandons an in-flight fetch; the stale done is ignored.
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("stale.rd", 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        do_reset("stale");
        apply(1'b1, 1'b1, 16'hEEEE, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("stale.done", 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_outs("stale.rd2", 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_outs("stale.fresh", 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000, 16'h0002, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        do_reset("rnd");
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % (m_halted ? 32'd12 : 32'd400)) == 0) begin
                do_reset("rnd");
                continue;
            end
            r_busy  = ($urandom % 4) == 0;
            r_redir = ($urandom % 12) == 0;
            r_npc   = 16'($urandom);
            if (($urandom % 6) != 0) r_npc[0] = 1'b0;
            r_hlt   = ($urandom % 30) == 0;
            r_stl   = ($urandom % 2) == 0;
            r_data  = 16'($urandom);
            if (m_out) begin
                r_done = (lat == 0);
                if (lat != 0) lat--;
            end else begin
                r_done = ($urandom % 10) == 0;
            end
            apply(r_busy, r_done, r_data, r_redir, r_npc, r_hlt, r_stl);
            e_rd = !m_halted && !m_out && !m_valid && !r_busy && !r_redir;
            check_outs("rnd", e_rd, {m_pc[15:1], 1'b0}, m_valid, m_instr, m_pcout, m_pcinc,
                       m_halted, m_err);
            model_step(r_busy, r_done, r_data, r_redir, r_npc, r_hlt, r_stl, issued);
            if (issued) lat = $urandom_range(0, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
